// File: rtl/amount_sel_pkg.sv
// Shared types and defaults for the amount selector: state encoding,
// default debounce/timeout lengths and saturating step helpers.
package amount_sel_pkg;

  typedef enum logic [2:0] {IDLE, S100, S200, S300, S400} amount_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 500_000_000;

  function automatic amount_state_t step_up(input amount_state_t s);
    amount_state_t r;
    case (s)
      IDLE:    r = S100;
      S100:    r = S200;
      S200:    r = S300;
      S300:    r = S400;
      S400:    r = S400;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  function automatic amount_state_t step_down(input amount_state_t s);
    amount_state_t r;
    case (s)
      IDLE:    r = IDLE;
      S100:    r = IDLE;
      S200:    r = S100;
      S300:    r = S200;
      S400:    r = S300;
      default: r = IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchronizer, debounce counter and a
// registered rising-edge pulse (one pulse per accepted press).
module btn_debounce
  import amount_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    prev_d   = stable_q;
    press_d  = stable_q & ~prev_q;
    // Level must disagree with the stable value for DEBOUNCE_CYCLES edges in a row
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/amount_sel_fsm.sv
// Button-driven amount selector: three debounced buttons step a five-state
// Moore FSM with one-hot Q100..Q400 flags. AUTO_RETURN_EN adds an idle timeout.
module amount_sel_fsm
  import amount_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc,
  input  logic btn_dec,
  input  logic btn_clr,
  output logic Q100,
  output logic Q200,
  output logic Q300,
  output logic Q400
);

  logic [2:0] btn_raw_vec;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic       p_inc, p_dec, p_clr;

  assign btn_raw_vec = {btn_clr, btn_dec, btn_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw_vec[gi]),
        .level  (btn_level[gi]),
        .press  (btn_press[gi])
      );
    end
  endgenerate

  assign p_inc = btn_press[0];
  assign p_dec = btn_press[1];
  assign p_clr = btn_press[2];

  amount_state_t state_q, state_d;

`ifdef AUTO_RETURN_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    if (p_clr) begin
      state_d = IDLE;
    end else if (p_inc && p_dec) begin
      state_d = state_q;
    end else if (p_inc) begin
      state_d = step_up(state_q);
    end else if (p_dec) begin
      state_d = step_down(state_q);
    end

`ifdef AUTO_RETURN_EN
    tmo_d = '0;
    // A pulse in the expiry cycle wins: the counter restarts instead of returning
    if ((state_q != IDLE) && !(p_inc || p_dec || p_clr)) begin
      if (tmo_q == TMO_MAX) begin
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
`ifdef AUTO_RETURN_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef AUTO_RETURN_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign Q100 = (state_q == S100);
  assign Q200 = (state_q == S200);
  assign Q300 = (state_q == S300);
  assign Q400 = (state_q == S400);

endmodule

// File: tb/tb_amount_sel_fsm.sv
// Self-checking bench for amount_sel_fsm: directed scenarios plus random
// button traffic checked against a run-length/integer reference model.
module tb_amount_sel_fsm;

  localparam int D = 4;
  localparam int T = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic btn_clr = 1'b0;
  logic Q100, Q200, Q300, Q400;

  always #5 clk = ~clk;

  amount_sel_fsm #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .btn_clr(btn_clr),
    .Q100   (Q100),
    .Q200   (Q200),
    .Q300   (Q300),
    .Q400   (Q400)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: amount 0..4, per-button delayed samples, run lengths
  int amount = 0;
  int idle_cnt = 0;
  bit dl0[3], dl1[3], prev_d[3], stable[3], pend_a[3], pend_b[3];
  int run[3];

  function automatic logic [3:0] onehot(input int a);
    logic [3:0] r;
    r = 4'b0000;
    if (a > 0) r[a-1] = 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] dut_q();
    return {Q400, Q300, Q200, Q100};
  endfunction

  function automatic bit raw_btn(input int b);
    bit r;
    case (b)
      0:       r = btn_inc;
      1:       r = btn_dec;
      default: r = btn_clr;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    bit fi, fd, fc, d, acc;
    int old;
    if (rst) begin
      amount = 0;
      idle_cnt = 0;
      for (int b = 0; b < 3; b++) begin
        dl0[b] = 0; dl1[b] = 0; prev_d[b] = 0; stable[b] = 0;
        pend_a[b] = 0; pend_b[b] = 0; run[b] = 0;
      end
    end else begin
      fi = pend_b[0];
      fd = pend_b[1];
      fc = pend_b[2];
      old = amount;
      if (fc) amount = 0;
      else if (fi && fd) amount = amount;
      else if (fi) amount = (amount < 4) ? amount + 1 : 4;
      else if (fd) amount = (amount > 0) ? amount - 1 : 0;
`ifdef AUTO_RETURN_EN
      if (fi || fd || fc || old == 0) begin
        idle_cnt = 0;
      end else if (idle_cnt == T - 1) begin
        amount = 0;
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
`endif
      for (int b = 0; b < 3; b++) begin
        d = dl1[b];
        run[b] = (d == prev_d[b]) ? run[b] + 1 : 1;
        prev_d[b] = d;
        acc = 0;
        if (d != stable[b] && run[b] >= D) begin
          stable[b] = d;
          acc = d;
        end
        pend_b[b] = pend_a[b];
        pend_a[b] = acc;
        dl1[b] = dl0[b];
        dl0[b] = raw_btn(b);
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed Q400..Q100=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag, dut_q(), onehot(amount));
  endtask

  task automatic press(input logic [2:0] btns, input int hold, input int gap, input string tag);
    {btn_clr, btn_dec, btn_inc} = btns;
    repeat (hold) cycle(tag);
    {btn_clr, btn_dec, btn_inc} = 3'b000;
    repeat (gap) cycle(tag);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) cycle("reset_model");
    check("reset_state", dut_q(), 4'b0000);
    rst = 1'b0;
    repeat (3) cycle("post_reset");

    // 1: held increment, Q100 visible exactly 7 edges after the sampled rise
    btn_inc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle("held_inc_model");
      check("held_inc_latency", dut_q(), (k >= 7) ? 4'b0001 : 4'b0000);
    end
    btn_inc = 1'b0;
    repeat (8) cycle("held_inc_release");
    press(3'b100, 6, 8, "clr");
    check("clr_to_idle", dut_q(), 4'b0000);

    // 2: saturation up then down
    for (int i = 1; i <= 6; i++) begin
      press(3'b001, 6, 8, "inc_seq");
      check("inc_saturate", dut_q(), onehot((i < 4) ? i : 4));
    end
    for (int i = 1; i <= 5; i++) begin
      press(3'b010, 6, 8, "dec_seq");
      check("dec_saturate", dut_q(), onehot((4 - i > 0) ? 4 - i : 0));
    end

    // 3: 3-cycle glitch rejected, exactly D cycles accepted
    press(3'b001, 3, 10, "glitch");
    check("glitch_rejected", dut_q(), 4'b0000);
    press(3'b001, D, 10, "min_press");
    check("min_press_accepted", dut_q(), 4'b0001);

    // 4: simultaneous inc+dec holds, clr beats inc
    press(3'b001, 6, 8, "to_s200");
    press(3'b001, 6, 8, "to_s300");
    press(3'b011, 6, 8, "inc_dec");
    check("inc_dec_hold", dut_q(), 4'b0100);
    press(3'b101, 6, 8, "clr_inc");
    check("clr_priority", dut_q(), 4'b0000);

    // 5: reset mid-debounce discards the partial press
    press(3'b001, 6, 8, "to_s100");
    press(3'b001, 6, 8, "to_s200b");
    btn_inc = 1'b1;
    repeat (3) cycle("mid_debounce");
    rst = 1'b1;
    cycle("mid_rst");
    check("mid_rst_clears", dut_q(), 4'b0000);
    rst = 1'b0;
    repeat (2) cycle("short_after_rst");
    btn_inc = 1'b0;
    repeat (10) cycle("short_after_rst_rel");
    check("partial_discarded", dut_q(), 4'b0000);
    btn_inc = 1'b1;
    rst = 1'b1;
    cycle("rst_held_btn");
    rst = 1'b0;
    repeat (12) cycle("held_through_rst");
    check("held_through_rst", dut_q(), 4'b0001);
    btn_inc = 1'b0;
    repeat (8) cycle("held_through_rst_rel");

    // 6: idle in S400 for 1000 cycles
    for (int i = 0; i < 3; i++) press(3'b001, 6, 8, "to_s400");
    check("at_s400", dut_q(), 4'b1000);
    repeat (1000) cycle("idle_s400");
`ifdef AUTO_RETURN_EN
    check("s400_timeout", dut_q(), 4'b0000);
`else
    check("s400_holds", dut_q(), 4'b1000);
`endif

    // Random traffic with occasional resets
    for (int s = 0; s < 150; s++) begin
      int sel;
      logic [2:0] btns;
      sel = $urandom_range(0, 9);
      if (sel <= 3) btns = 3'b001;
      else if (sel <= 6) btns = 3'b010;
      else if (sel == 7) btns = 3'b100;
      else if (sel == 8) btns = 3'b011;
      else btns = 3'b000;
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        cycle("rand_rst");
        rst = 1'b0;
      end
      press(btns, $urandom_range(1, 9), $urandom_range(1, 9), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
